// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Lets NUM_REQ sprite renderers share one sprite ROM. Each vga_clk edge grants
// at most one requester, drives its address to the ROM, and later returns the
// ROM data with a one-hot tag naming the requester. Fully pipelined: one grant
// per cycle and no bubbles between back-to-back grants.
//
// Arbitration is round-robin by default. If the macro SPRITE_ARB_FIXED_PRIO_EN
// is defined, arbitration is fixed priority instead: the lowest index wins and
// there is no round-robin pointer.
//
// Ports
//   vga_clk      in   pixel clock; all state changes on its rising edge
//   reset        in   asynchronous, active-high
//   req          in   [NUM_REQ]         request per requester, held until gnt
//   req_addr     in   [NUM_REQ*ADDR_W]  ROM address; slice i belongs to requester i
//   gnt          out  [NUM_REQ]         registered one-hot grant, one-cycle pulse
//   rom_address  out  [ADDR_W]          registered address to the shared ROM
//   rom_q        in   [DATA_W]          ROM read data, ROM_LAT edges after the address
//   rsp_valid    out  [NUM_REQ]         one-hot owner of rsp_data for this cycle
//   rsp_data     out  [DATA_W]          registered ROM data; holds when not valid
//   busy         out  a grant or a ROM read is in flight
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 0
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]   base_s;
    logic [PTR_W:0]     sum_s;
    logic [PTR_W-1:0]   idx_s;
    logic               take_s;
    logic               found_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   win_s;
    logic [ADDR_W-1:0]  addr_s;
    logic               busy_nxt_s;

    // Stage 0 is the grant itself; stage ROM_LAT lines up with rom_q.
    logic [NUM_REQ-1:0] tag_r [0:ROM_LAT];
    logic [ADDR_W-1:0]  rom_address_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [DATA_W-1:0]  rsp_data_r;
    logic               busy_r;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign base_s = {PTR_W{1'b0}};
`else
    logic [PTR_W-1:0] rr_ptr_r;

    assign base_s = rr_ptr_r;

    // Round-robin pointer: after a grant to w, the search starts at w+1.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (|grant_s) begin
            rr_ptr_r <= (win_s == PTR_W'(NUM_REQ-1)) ? {PTR_W{1'b0}} : win_s + PTR_W'(1'b1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Winner search: scan from base_s upward with wrap; the first set req wins.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        win_s   = {PTR_W{1'b0}};
        found_s = 1'b0;
        sum_s   = {(PTR_W+1){1'b0}};
        idx_s   = {PTR_W{1'b0}};
        take_s  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s   = {1'b0, base_s} + (PTR_W+1)'(off);
            idx_s   = (sum_s >= NUM_REQ_W) ? PTR_W'(sum_s - NUM_REQ_W) : PTR_W'(sum_s);
            take_s  = req[idx_s] & ~found_s;
            grant_s = take_s ? (ONE_HOT0 << idx_s) : grant_s;
            win_s   = take_s ? idx_s : win_s;
            found_s = found_s | req[idx_s];
        end
    end

    // Address mux: select the winner's slice of req_addr.
    always_comb begin
        addr_s = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_s = (win_s == PTR_W'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : addr_s;
        end
    end

    // Next busy: a grant is being issued now, or a stage will still hold a read.
    always_comb begin
        busy_nxt_s = |grant_s;
        for (int i = 0; i < ROM_LAT; i++) begin
            busy_nxt_s = busy_nxt_s | (|tag_r[i]);
        end
    end

    // Grant/address registers, tag pipeline and response capture.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_r[i] <= {NUM_REQ{1'b0}};
            end
            rom_address_r <= {ADDR_W{1'b0}};
            rsp_valid_r   <= {NUM_REQ{1'b0}};
            rsp_data_r    <= {DATA_W{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            tag_r[0] <= grant_s;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            if (|grant_s) begin
                rom_address_r <= addr_s;
            end else begin
                rom_address_r <= rom_address_r;
            end
            rsp_valid_r <= tag_r[ROM_LAT];
            if (|tag_r[ROM_LAT]) begin
                rsp_data_r <= rom_q;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign gnt         = tag_r[0];
    assign rom_address = rom_address_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign busy        = busy_r;

endmodule
